oh_dec_skid: RTL and testbench

//   Binary-index to one-hot decoder; the inverse of the team's 4-to-2 priority encoder (index + hit -> one-hot).

---
 rtl/oh_dec_skid.sv | 84 ++++++++
 tb/tb_oh_dec_skid.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/oh_dec_skid.sv
// Binary-index to one-hot decoder behind a valid/ready handshake, with a
// two-entry (main + skid) output buffer that keeps in_rdy registered at full throughput.
module oh_dec_skid #(
  parameter  int OHW = 4,
  localparam int BW  = $clog2(OHW)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [BW-1:0]  in_bin,
  input  logic           in_hit,
  input  logic           in_vld,
  output logic           in_rdy,
  output logic [OHW-1:0] out_oht,
  output logic           out_err,
  output logic           out_vld,
  input  logic           out_rdy
);

  logic           acc;
  logic           con;
  logic           s_vld;
  logic           s_vld_nxt;
  logic [OHW-1:0] s_oht;
  logic           s_err;
  logic [OHW-1:0] dec_oht;
  logic           dec_err;

  // Decode the incoming beat; an out-of-range index only flags err.
  always_comb begin
    dec_oht = '0;
    dec_err = in_hit && (int'(in_bin) >= OHW);
    for (int i = 0; i < OHW; i++)
      dec_oht[i] = in_hit && (int'(in_bin) == i);
  end

  // NOTE: every signal assigned in always_comb gets a value on all paths, so no latch is inferred.
  always_comb begin
    acc       = in_vld && in_rdy;
    con       = out_vld && out_rdy;
    s_vld_nxt = s_vld;
    if (con)
      s_vld_nxt = 1'b0;
    else if (acc && out_vld)
      s_vld_nxt = 1'b1;
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld <= 1'b0;
      out_oht <= '0;
      out_err <= 1'b0;
      s_vld   <= 1'b0;
      in_rdy  <= 1'b1;
    end else begin
      s_vld  <= s_vld_nxt;
      in_rdy <= !s_vld_nxt;
      if (con) begin
        if (s_vld) begin
          out_oht <= s_oht;
          out_err <= s_err;
        end else if (acc) begin
          out_oht <= dec_oht;
          out_err <= dec_err;
        end else begin
          out_vld <= 1'b0;
        end
      end else if (acc && !out_vld) begin
        out_vld <= 1'b1;
        out_oht <= dec_oht;
        out_err <= dec_err;
      end
    end
  end

  // NOTE: skid payload is not reset; it is only ever read while s_vld marks it valid.
  always_ff @(posedge clk) begin
    if (!con && acc && out_vld) begin
      s_oht <= dec_oht;
      s_err <= dec_err;
    end
  end

endmodule

// File: tb/tb_oh_dec_skid.sv
// Self-checking bench for oh_dec_skid: directed cases plus randomized traffic
// on an OHW=4 and an OHW=5 instance, each compared against a FIFO reference model.
module tb_oh_dec_skid;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0] bin4 = '0;
  logic       hit4 = 1'b0, vld4 = 1'b0, ordy4 = 1'b0;
  logic       rdy4, err4, ovld4;
  logic [3:0] oht4;

  logic [2:0] bin5 = '0;
  logic       hit5 = 1'b0, vld5 = 1'b0, ordy5 = 1'b0;
  logic       rdy5, err5, ovld5;
  logic [4:0] oht5;

  oh_dec_skid #(.OHW(4)) dut4 (
    .clk(clk), .rst(rst), .in_bin(bin4), .in_hit(hit4), .in_vld(vld4), .in_rdy(rdy4),
    .out_oht(oht4), .out_err(err4), .out_vld(ovld4), .out_rdy(ordy4)
  );

  oh_dec_skid #(.OHW(5)) dut5 (
    .clk(clk), .rst(rst), .in_bin(bin5), .in_hit(hit5), .in_vld(vld5), .in_rdy(rdy5),
    .out_oht(oht5), .out_err(err5), .out_vld(ovld5), .out_rdy(ordy5)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: each instance is a FIFO of at most two decoded beats, {err, oht[4:0]}.
  logic [5:0] q4[$];
  logic [5:0] q5[$];

  function automatic logic [5:0] expect_word(input int bin, input bit hit, input int w);
    logic [5:0] r;
    r = '0;
    if (hit && bin < w) r = 6'(1 << bin);
    if (hit && bin >= w) r[5] = 1'b1;
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance one clock, update the models from the handshake seen before the edge, compare.
  task automatic step();
    bit acc4, con4, acc5, con5;
    logic [5:0] e;
    acc4 = vld4 && (q4.size() < 2);
    con4 = (q4.size() != 0) && ordy4;
    acc5 = vld5 && (q5.size() < 2);
    con5 = (q5.size() != 0) && ordy5;
    e = '0;
    @(posedge clk);
    #1;
    if (rst) begin
      q4.delete();
      q5.delete();
    end else begin
      if (con4) void'(q4.pop_front());
      if (acc4) q4.push_back(expect_word(int'(bin4), hit4, 4));
      if (con5) void'(q5.pop_front());
      if (acc5) q5.push_back(expect_word(int'(bin5), hit5, 5));
    end
    check("rdy4", 32'(rdy4), 32'(q4.size() < 2));
    check("vld4", 32'(ovld4), 32'(q4.size() != 0));
    if (q4.size() != 0) begin
      e = q4[0];
      check("oht4", 32'(oht4), 32'(e[3:0]));
      check("err4", 32'(err4), 32'(e[5]));
    end
    check("rdy5", 32'(rdy5), 32'(q5.size() < 2));
    check("vld5", 32'(ovld5), 32'(q5.size() != 0));
    if (q5.size() != 0) begin
      e = q5[0];
      check("oht5", 32'(oht5), 32'(e[4:0]));
      check("err5", 32'(err5), 32'(e[5]));
    end
  endtask

  initial begin
    // T1: reset held two cycles with a valid beat presented.
    rst = 1'b1; vld4 = 1'b1; bin4 = 2'd1; hit4 = 1'b1; vld5 = 1'b1; bin5 = 3'd2; hit5 = 1'b1;
    step(); step();
    rst = 1'b0; vld4 = 1'b0; vld5 = 1'b0;
    check("t1_vld", 32'(ovld4), 32'd0);
    check("t1_oht", 32'(oht4), 32'd0);
    check("t1_err", 32'(err4), 32'd0);
    check("t1_rdy", 32'(rdy4), 32'd1);
    step();

    // T2: back-to-back sweep of every index.
    ordy4 = 1'b1; hit4 = 1'b1;
    for (int b = 0; b < 4; b++) begin
      logic [3:0] want;
      want = 4'(1 << b);
      bin4 = 2'(b); vld4 = 1'b1;
      step();
      check("t2_oht", 32'(oht4), 32'(want));
      check("t2_vld", 32'(ovld4), 32'd1);
    end
    vld4 = 1'b0;
    step();

    // T3: no hit decodes to zero regardless of index.
    bin4 = 2'd2; hit4 = 1'b0; vld4 = 1'b1;
    step();
    vld4 = 1'b0;
    check("t3_vld", 32'(ovld4), 32'd1);
    check("t3_oht", 32'(oht4), 32'd0);
    check("t3_err", 32'(err4), 32'd0);
    step();

    // T4: backpressure fills main and skid, then drains in order.
    ordy4 = 1'b0; hit4 = 1'b1; vld4 = 1'b1;
    bin4 = 2'd1; step();
    bin4 = 2'd2; step();
    check("t4_full", 32'(rdy4), 32'd0);
    bin4 = 2'd3; step();
    check("t4_hold", 32'(oht4), 32'b0010);
    check("t4_stall", 32'(rdy4), 32'd0);
    ordy4 = 1'b1; step();
    check("t4_2nd", 32'(oht4), 32'b0100);
    step();
    check("t4_3rd", 32'(oht4), 32'b1000);
    vld4 = 1'b0; step();
    check("t4_empty", 32'(ovld4), 32'd0);

    // T5: non-power-of-two width flags out-of-range indices.
    ordy5 = 1'b1; hit5 = 1'b1; vld5 = 1'b1;
    bin5 = 3'd6; step();
    check("t5_err", 32'(err5), 32'd1);
    check("t5_oht0", 32'(oht5), 32'd0);
    bin5 = 3'd4; step();
    check("t5_oht4", 32'(oht5), 32'b10000);
    check("t5_ok", 32'(err5), 32'd0);
    vld5 = 1'b0; step();

    // T6: reset while full discards both stored beats.
    ordy4 = 1'b0; vld4 = 1'b1; hit4 = 1'b1;
    bin4 = 2'd0; step();
    bin4 = 2'd3; step();
    check("t6_full", 32'(rdy4), 32'd0);
    vld4 = 1'b0; rst = 1'b1; step();
    rst = 1'b0;
    check("t6_vld", 32'(ovld4), 32'd0);
    check("t6_rdy", 32'(rdy4), 32'd1);
    ordy4 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t6_gone", 32'(ovld4), 32'd0);
    end

    // Randomized traffic; a stalled producer holds its beat.
    for (int i = 0; i < 3000; i++) begin
      if (!(vld4 && q4.size() >= 2)) begin
        vld4 = ($urandom_range(3) != 0);
        bin4 = 2'($urandom_range(3));
        hit4 = ($urandom_range(4) != 0);
      end
      if (!(vld5 && q5.size() >= 2)) begin
        vld5 = ($urandom_range(3) != 0);
        bin5 = 3'($urandom_range(7));
        hit5 = ($urandom_range(4) != 0);
      end
      ordy4 = ($urandom_range(2) != 0);
      ordy5 = ($urandom_range(2) != 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
